// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 line signals for the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  logic tx_error;
  logic ps2_clk_in;
  logic ps2_dat_in;
  logic ps2_clk_oe;
  logic ps2_dat_oe;
  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe
  );
  modport slave (
    input tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with inhibit, start, odd parity, ACK check and timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic clk,
  input logic reset,
  ps2_host_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, tmo, tmo_n;
  logic [3:0] idx, idx_n;
  logic [7:0] data, data_n;
  logic par, par_n;
  logic clk_oe, clk_oe_n, dat_oe, dat_oe_n, done, done_n, err, err_n, ready;
  logic [1:0] cs, ds;
  logic cprev, fall, tmo_hit;
  assign fall = cprev & ~cs[1];
  assign tmo_hit = tmo == 32'(TIMEOUT_CYCLES - 1);
  assign bus.ps2_clk_oe = clk_oe;
  assign bus.ps2_dat_oe = dat_oe;
  assign bus.tx_done = done;
  assign bus.tx_error = err;
  assign bus.tx_ready = ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cs <= 2'b11;
      ds <= 2'b11;
      cprev <= 1'b1;
      cnt <= '0;
      tmo <= '0;
      idx <= '0;
      data <= '0;
      par <= 1'b0;
      clk_oe <= 1'b0;
      dat_oe <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_n;
      cs <= {cs[0], bus.ps2_clk_in};
      ds <= {ds[0], bus.ps2_dat_in};
      cprev <= cs[1];
      cnt <= cnt_n;
      tmo <= tmo_n;
      idx <= idx_n;
      data <= data_n;
      par <= par_n;
      clk_oe <= clk_oe_n;
      dat_oe <= dat_oe_n;
      done <= done_n;
      err <= err_n;
      ready <= state_n == IDLE;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tmo_n = tmo;
    idx_n = idx;
    data_n = data;
    par_n = par;
    clk_oe_n = clk_oe;
    dat_oe_n = dat_oe;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (bus.tx_valid && ready) begin
          data_n = bus.tx_data;
          par_n = ~^bus.tx_data;
          cnt_n = '0;
          clk_oe_n = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1;
        if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_n = '0;
          dat_oe_n = 1'b1;
          state_n = START;
        end
      end
      START: begin
        cnt_n = cnt + 1;
        if (cnt == 32'(START_CYCLES - 1)) begin
          clk_oe_n = 1'b0;
          tmo_n = '0;
          idx_n = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        tmo_n = tmo + 1;
        if (tmo_hit) begin
          dat_oe_n = 1'b0;
          err_n = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          idx_n = idx + 4'd1;
          dat_oe_n = idx < 4'd8 ? ~data[idx[2:0]] : idx == 4'd8 ? ~par : 1'b0;
          state_n = idx == 4'd9 ? ACK : SEND;
        end
      end
      ACK: begin
        tmo_n = tmo + 1;
        if (tmo_hit) begin
          dat_oe_n = 1'b0;
          err_n = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          done_n = ~ds[1];
          err_n = ds[1];
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        tmo_n = tmo + 1;
        state_n = (tmo_hit || (cs[1] && ds[1])) ? IDLE : WAIT_IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven frames against a PS/2 device model plus timeout and reset sequences
module tb_ps2_host_tx;
  localparam int TMO = 300;
  typedef struct {
    logic [7:0] data;
    logic ack;
    logic [9:0] oe;
    int done;
    int err;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat_low = 1'b0;
  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  vec_t vecs[6];
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(10), .START_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & ~dev_dat_low;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.tx_done) n_done <= n_done + 1;
    if (bus.tx_error) n_err <= n_err + 1;
    if (bus.tx_done && bus.tx_error) n_both <= n_both + 1;
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic dev_edge(input int k, input logic [9:0] exp_oe);
    dev_clk = 1'b0;
    repeat (8) @(negedge clk);
    if (k <= 10) check($sformatf("oe_edge%0d", k), int'(bus.ps2_dat_oe), int'(exp_oe[k-1]));
    dev_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic start_req(input logic [7:0] d);
    int cyc;
    int rise;
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data = ~d;
    check("accept_latency", int'(bus.ps2_clk_oe), 1);
    cyc = 1;
    rise = 0;
    while (bus.ps2_clk_oe && cyc < 100) begin
      if (bus.ps2_dat_oe && rise == 0) rise = cyc;
      bus.tx_valid = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    bus.tx_valid = 1'b0;
    check("clk_oe_high", cyc - 1, 14);
    check("dat_rise", rise, 11);
    check("start_bit", int'(bus.ps2_dat_oe), 1);
  endtask
  task automatic run_frame(input vec_t v);
    int d0;
    int e0;
    int w;
    d0 = n_done;
    e0 = n_err;
    start_req(v.data);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 10; k++) dev_edge(k, v.oe);
    dev_dat_low = v.ack;
    dev_edge(11, v.oe);
    repeat (4) @(negedge clk);
    dev_dat_low = 1'b0;
    w = 0;
    while (!bus.tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_back", int'(bus.tx_ready), 1);
    check("lines_released", int'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 0);
    check("done_cnt", n_done - d0, v.done);
    check("err_cnt", n_err - e0, v.err);
  endtask
  initial begin
    int cyc;
    int d0;
    int e0;
    vecs[0] = '{8'hED, 1'b1, 10'h012, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 10'h0FF, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 10'h000, 1, 0};
    vecs[3] = '{8'h01, 1'b0, 10'h1FE, 0, 1};
    vecs[4] = '{8'h80, 1'b1, 10'h17F, 1, 0};
    vecs[5] = '{8'h0F, 1'b1, 10'h0F0, 1, 0};
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", int'(bus.ps2_clk_oe), 0);
    check("rst_dat_oe", int'(bus.ps2_dat_oe), 0);
    check("rst_ready", int'(bus.tx_ready), 1);
    check("rst_pulses", int'({bus.tx_done, bus.tx_error}), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);
    d0 = n_done;
    e0 = n_err;
    start_req(8'h3C);
    cyc = 0;
    while (!bus.tx_error && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycles", cyc, TMO);
    check("timeout_oe", int'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 0);
    @(negedge clk);
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_done_cnt", n_done - d0, 0);
    check("timeout_ready", int'(bus.tx_ready), 1);
    d0 = n_done;
    e0 = n_err;
    start_req(8'hED);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 5; k++) dev_edge(k, vecs[0].oe);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_oe", int'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 0);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_pulses", (n_done - d0) + (n_err - e0), 0);
    run_frame(vecs[0]);
    check("never_both", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000: clock-low inhibit time before start (100 us at 100 MHz).
REQ-002 SHALL have parameter START_CYCLES, default 16: time data is held low before the clock is released.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000: abort limit measured from clock release (20 ms at 100 MHz).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port tx_data, input, 8: command byte to send to the device.
REQ-007 SHALL have port tx_valid, input, 1: request; the byte is accepted when tx_valid and tx_ready are both 1.
REQ-008 SHALL have port tx_ready, output, 1: high only in IDLE.
REQ-009 SHALL have port ps2_clk_in, input, 1: raw PS/2 clock line level from the loan IO input.
REQ-010 SHALL have port ps2_dat_in, input, 1: raw PS/2 data line level from the loan IO input.
REQ-011 SHALL have port ps2_clk_oe, output, 1: 1 pulls the clock line low (loan IO out tied 0); 0 releases it.
REQ-012 SHALL have port ps2_dat_oe, output, 1: 1 pulls the data line low; 0 releases it.
REQ-013 SHALL have port tx_done, output, 1: one-cycle pulse when the device acknowledges.
REQ-014 SHALL have port tx_error, output, 1: one-cycle pulse on missing ACK or timeout.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_dat_in each through a 2-flop synchronizer; all decisions use synchronized values only.
REQ-016 SHALL define a falling edge as the synchronized clock being 1 in the previous cycle and 0 in the current cycle.
REQ-017 SHALL implement the states IDLE, INHIBIT, START, SEND, ACK and WAIT_IDLE; all outputs are registered.
REQ-018 IDLE: SHALL hold both oe at 0; on accept, latch tx_data, compute parity = XNOR-reduce(tx_data) (odd parity), and enter INHIBIT.
REQ-019 INHIBIT: SHALL hold clk_oe=1 and dat_oe=0 for exactly INHIBIT_CYCLES cycles, then enter START.
REQ-020 START: SHALL hold clk_oe=1 and dat_oe=1 for START_CYCLES cycles, then set clk_oe=0, clear the timeout counter, clear the bit index, and enter SEND.
REQ-021 SEND: SHALL keep clk_oe=0; on falling edges 1-8, set dat_oe = NOT tx_data[n-1] (LSB first).
REQ-022 SEND: on falling edge 9, SHALL set dat_oe = NOT parity; on falling edge 10, SHALL set dat_oe=0 (stop bit) and enter ACK.
REQ-023 ACK: on the next falling edge, SHALL sample the synchronized data line; 0 pulses tx_done, 1 pulses tx_error; either way, SHALL enter WAIT_IDLE.
REQ-024 WAIT_IDLE: SHALL return to IDLE when the synchronized clock and data are both 1.
REQ-025 The timeout counter SHALL run in SEND, ACK and WAIT_IDLE.
REQ-026 If the timeout reaches TIMEOUT_CYCLES in SEND or ACK, SHALL release both oe, pulse tx_error, and enter IDLE.
REQ-027 If the timeout reaches TIMEOUT_CYCLES in WAIT_IDLE, SHALL enter IDLE with no error pulse.
REQ-028 tx_done and tx_error SHALL never be asserted in the same cycle; each completed request SHALL produce exactly one of them.
REQ-029 tx_valid outside IDLE SHALL be ignored; tx_data changes after accept SHALL not affect the frame in flight.
REQ-030 Falling edges seen in IDLE, INHIBIT or START SHALL be ignored (no bit advance).
REQ-031 Latency: the accept cycle SHALL be followed by clk_oe=1 on the next clock.

Reset
REQ-032 While reset=1 at a clock edge, SHALL force the state to IDLE, clk_oe=0, dat_oe=0, tx_done=0, tx_error=0, tx_ready=1 on the next cycle, and clear the counters, bit index and synchronizers to 1.
REQ-033 Reset mid-frame SHALL release both lines on the next clock with no done/error pulse.
REQ-034 The module SHALL accept a new request on the first cycle after reset deasserts.

Verification
REQ-035 Send 0xED with a device model that ACKs: dat_oe after falling edges 1-10 = 0,1,0,0,1,0,0,0,0,0 (bits 1,0,1,1,0,1,1,1, parity 1, stop); then tx_done pulses once.
REQ-036 Send 0x00 and check parity: the value driven on the line at edge 9 is 1 (dat_oe=0).
REQ-037 Device holds data high at the 11th edge: tx_error pulses once, no tx_done; tx_ready returns to 1 after both lines go high.
REQ-038 Device never clocks after release: tx_error exactly TIMEOUT_CYCLES cycles after clk_oe falls; both oe=0.
REQ-039 Timing, INHIBIT_CYCLES=10 and START_CYCLES=4: clk_oe high for 14 cycles; dat_oe rises at cycle 11 after clk_oe rises; tx_valid pulsed during the frame is ignored.
REQ-040 Assert reset after edge 5: both oe=0 the next cycle, no pulses; the next request completes normally.
